// File: rtl/leaf_packet_tx_pkg.sv
// Shared definitions for the leaf transmit packetizer: packet field layout,
// credit constants and the FSM state type.
package leaf_packet_tx_pkg;

  localparam int PAYLOAD_BITS          = 32;
  localparam int NUM_LEAF_BITS         = 5;
  localparam int NUM_PORT_BITS         = 4;
  localparam int NUM_ADDR_BITS         = 7;
  localparam int PACKET_BITS           = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS;
  localparam int FREESPACE_UPDATE_SIZE = 64;

  localparam int ADDR_LSB  = PAYLOAD_BITS;
  localparam int PORT_LSB  = ADDR_LSB + NUM_ADDR_BITS;
  localparam int LEAF_LSB  = PORT_LSB + NUM_PORT_BITS;
  localparam int VALID_BIT = LEAF_LSB + NUM_LEAF_BITS;

  // One credit per receiver buffer entry; one extra bit so the full count fits.
  localparam int CREDIT_BITS = NUM_ADDR_BITS + 1;
  localparam int CREDIT_INIT = 2 ** NUM_ADDR_BITS;

  typedef logic [PACKET_BITS-1:0] packet_t;

  typedef enum logic {ST_RUN, ST_STALL} tx_state_e;

  function automatic packet_t make_packet(input logic [NUM_LEAF_BITS-1:0] leaf,
                                          input logic [NUM_PORT_BITS-1:0] port,
                                          input logic [NUM_ADDR_BITS-1:0] addr,
                                          input logic [PAYLOAD_BITS-1:0]  payload);
    return {1'b1, leaf, port, addr, payload};
  endfunction

endpackage

// File: rtl/leaf_packet_tx_if.sv
// User-stream and BFT-side signals of one leaf transmit port. The packetizer
// takes the master view; the user kernel / BFT environment takes the slave view.
interface leaf_packet_tx_if;
  import leaf_packet_tx_pkg::*;

  logic [PAYLOAD_BITS-1:0]  din_user2tx;
  logic                     vld_user2tx;
  logic                     ack_tx2user;
  logic [NUM_LEAF_BITS-1:0] dst_leaf;
  logic [NUM_PORT_BITS-1:0] dst_port;
  logic                     freespace_upd;
  packet_t                  dout_tx2bft;
  logic                     bft_ready;
  logic [CREDIT_BITS-1:0]   credits;

  modport master (
    input  din_user2tx, vld_user2tx, dst_leaf, dst_port, freespace_upd, bft_ready,
    output ack_tx2user, dout_tx2bft, credits
  );

  modport slave (
    output din_user2tx, vld_user2tx, dst_leaf, dst_port, freespace_upd, bft_ready,
    input  ack_tx2user, dout_tx2bft, credits
  );
endinterface

// File: rtl/leaf_packet_tx_skid.sv
// Two-entry packet buffer between user acceptance and BFT issue. Head is shown
// as all-zero when empty so the BFT never sees a stale valid bit.
module leaf_packet_tx_skid
  import leaf_packet_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  packet_t    push_pkt,
  input  logic       pop,
  output packet_t    head,
  output logic [1:0] count
);

  packet_t pkt_p0, pkt_p1;
  logic    vld_p0, vld_p1;
  logic    pop_ok;

  assign pop_ok = pop & vld_p0;

  // Occupancy control: vld_p1 is only ever set while vld_p0 is set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else if (push && !pop_ok) begin
      if (vld_p0) vld_p1 <= 1'b1;
      else        vld_p0 <= 1'b1;
    end else if (pop_ok && !push) begin
      vld_p0 <= vld_p1;
      vld_p1 <= 1'b0;
    end
  end

  // Data slots: p0 is the head, p1 the overflow entry.
  always_ff @(posedge clk) begin
    if (pop_ok) begin
      pkt_p0 <= vld_p1 ? pkt_p1 : push_pkt;
      if (push) pkt_p1 <= push_pkt;
    end else if (push) begin
      if (!vld_p0)      pkt_p0 <= push_pkt;
      else if (!vld_p1) pkt_p1 <= push_pkt;
    end
  end

  assign head  = vld_p0 ? pkt_p0 : '0;
  assign count = 2'(vld_p0) + 2'(vld_p1);

endmodule

// File: rtl/leaf_packet_tx.sv
// Leaf transmit packetizer: wraps user words into BFT packets with sequence
// address, and throttles acceptance on receiver credits and skid occupancy.
module leaf_packet_tx
  import leaf_packet_tx_pkg::*;
(
  input logic              clk_bft,
  input logic              reset,
  leaf_packet_tx_if.master bus
);

  logic [CREDIT_BITS-1:0]   credits_q, credits_nxt;
  logic [CREDIT_BITS:0]     credit_sum;
  logic [NUM_ADDR_BITS-1:0] addr_q;
  logic                     ack_q, ack_nxt;
  tx_state_e                state_q, state_nxt;
  logic                     xfer, pop;
  logic [1:0]               count, count_nxt;
  packet_t                  head;

  function automatic logic [CREDIT_BITS-1:0] sat_credits(input logic [CREDIT_BITS:0] v);
    if (int'(v) > CREDIT_INIT) return CREDIT_BITS'(CREDIT_INIT);
    return v[CREDIT_BITS-1:0];
  endfunction

  assign xfer = bus.vld_user2tx & ack_q;
  assign pop  = head[VALID_BIT] & bus.bft_ready;

  // Credits are spent at acceptance, so a buffered packet already owns its slot.
  assign credit_sum  = {1'b0, credits_q}
                     + (bus.freespace_upd ? (CREDIT_BITS+1)'(FREESPACE_UPDATE_SIZE) : '0)
                     - (CREDIT_BITS+1)'(xfer);
  assign credits_nxt = sat_credits(credit_sum);
  assign count_nxt   = count + 2'(xfer) - 2'(pop);

  always_ff @(posedge clk_bft or posedge reset) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    ack_nxt   = 1'b0;
    case (state_q)
      ST_RUN:   if (xfer && credits_q == CREDIT_BITS'(1) && !bus.freespace_upd) state_nxt = ST_STALL;
      ST_STALL: if (bus.freespace_upd) state_nxt = ST_RUN;
    endcase
    ack_nxt = (state_nxt == ST_RUN) && (count_nxt < 2'd2) && (credits_nxt != '0);
  end

  always_ff @(posedge clk_bft or posedge reset) begin
    if (reset) begin
      credits_q <= CREDIT_BITS'(CREDIT_INIT);
      addr_q    <= '0;
      ack_q     <= 1'b0;
    end else begin
      credits_q <= credits_nxt;
      ack_q     <= ack_nxt;
      if (xfer) addr_q <= addr_q + 1'b1;
    end
  end

  // An update must never push credits past the receiver buffer depth.
  always @(posedge clk_bft) begin
    if (!reset && bus.freespace_upd)
      credit_overflow: assert (int'(credit_sum) <= CREDIT_INIT);
  end

  leaf_packet_tx_skid u_skid (
    .clk      (clk_bft),
    .rst      (reset),
    .push     (xfer),
    .push_pkt (make_packet(bus.dst_leaf, bus.dst_port, addr_q, bus.din_user2tx)),
    .pop      (pop),
    .head     (head),
    .count    (count)
  );

  assign bus.dout_tx2bft = head;
  assign bus.ack_tx2user = ack_q;
  assign bus.credits     = credits_q;

endmodule

// File: tb/tb_leaf_packet_tx.sv
// Bench for leaf_packet_tx: directed scenarios plus randomized traffic, all
// checked against a queue-based packet/credit model.
module tb_leaf_packet_tx;
  import leaf_packet_tx_pkg::*;

  logic clk_bft = 1'b0;
  logic reset   = 1'b0;
  always #5 clk_bft = ~clk_bft;

  leaf_packet_tx_if bus();

  leaf_packet_tx dut (
    .clk_bft (clk_bft),
    .reset   (reset),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: packets held inside the DUT, receiver credits, next address.
  packet_t m_q[$];
  int      m_credits;
  int      m_addr;
  bit      m_ack;

  int          n_issued;
  logic [4:0]  leaf;
  logic [3:0]  port;
  logic        xf, v, u, rdy, hold;
  logic [31:0] d;
  packet_t     held;
  int          guard;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge: check outputs, drive this cycle, advance the model.
  task automatic cycle(input logic cv, input logic [31:0] cd, input logic crdy,
                       input logic cu, output logic cxf);
    packet_t exp_dout;
    exp_dout = (m_q.size() > 0) ? m_q[0] : '0;
    check_eq("dout", 64'(bus.dout_tx2bft), 64'(exp_dout));
    check_eq("credits", 64'(bus.credits), 64'(m_credits));
    check_eq("ack", 64'(bus.ack_tx2user), 64'(m_ack));
    bus.vld_user2tx   = cv;
    bus.din_user2tx   = cd;
    bus.bft_ready     = crdy;
    bus.freespace_upd = cu;
    bus.dst_leaf      = leaf;
    bus.dst_port      = port;
    if (bus.dout_tx2bft[VALID_BIT] && crdy) n_issued++;
    cxf = cv && m_ack;
    if (m_q.size() > 0 && crdy) void'(m_q.pop_front());
    if (cxf) begin
      m_q.push_back({1'b1, leaf, port, 7'(m_addr), cd});
      m_addr = (m_addr + 1) % 128;
    end
    m_credits = m_credits - int'(cxf) + (cu ? 64 : 0);
    if (m_credits > 128) m_credits = 128;
    m_ack = (m_q.size() < 2) && (m_credits > 0);
    @(posedge clk_bft);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset             = 1'b1;
    bus.vld_user2tx   = 1'b0;
    bus.din_user2tx   = '0;
    bus.bft_ready     = 1'b0;
    bus.freespace_upd = 1'b0;
    bus.dst_leaf      = leaf;
    bus.dst_port      = port;
    m_q.delete();
    m_credits = 128;
    m_addr    = 0;
    m_ack     = 1'b0;
    #1;
    check_eq("rst_dout", 64'(bus.dout_tx2bft), 64'd0);
    check_eq("rst_credits", 64'(bus.credits), 64'd128);
    check_eq("rst_ack", 64'(bus.ack_tx2user), 64'd0);
    repeat (n) @(posedge clk_bft);
    #1;
    check_eq("rst_hold_ack", 64'(bus.ack_tx2user), 64'd0);
    check_eq("rst_hold_credits", 64'(bus.credits), 64'd128);
    reset = 1'b0;
  endtask

  initial begin
    leaf = '0;
    port = '0;
    hold = 1'b0;
    v    = 1'b0;
    d    = '0;
    bus.vld_user2tx   = 1'b0;
    bus.din_user2tx   = '0;
    bus.bft_ready     = 1'b0;
    bus.freespace_upd = 1'b0;
    bus.dst_leaf      = '0;
    bus.dst_port      = '0;
    @(posedge clk_bft);
    #1;

    // Reset held, then ack rises one cycle after release
    do_reset(5);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, xf);
    check_eq("ack_after_release", 64'(bus.ack_tx2user), 64'd1);

    // Known packet encoding
    leaf = 5'd3;
    port = 4'd2;
    cycle(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, xf);
    check_eq("pkt_deadbeef", 64'(bus.dout_tx2bft), 64'h1_1900_DEAD_BEEF);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, xf);

    // Credit exhaustion, address wrap, resume on update
    do_reset(2);
    leaf = 5'd17;
    port = 4'd11;
    n_issued = 0;
    repeat (140) cycle(1'b1, 32'hA5A5_0000 | 32'(m_addr), 1'b1, 1'b0, xf);
    check_eq("issued_128", 64'(n_issued), 64'd128);
    check_eq("exhaust_credits", 64'(bus.credits), 64'd0);
    check_eq("exhaust_ack", 64'(bus.ack_tx2user), 64'd0);
    cycle(1'b1, 32'hA5A5_0000 | 32'(m_addr), 1'b1, 1'b1, xf);
    n_issued = 0;
    cycle(1'b1, 32'hA5A5_0000 | 32'(m_addr), 1'b1, 1'b0, xf);
    check_eq("addr_after_upd", 64'(bus.dout_tx2bft[38:32]), 64'd0);
    repeat (70) cycle(1'b1, 32'hA5A5_0000 | 32'(m_addr), 1'b1, 1'b0, xf);
    check_eq("issued_64", 64'(n_issued), 64'd64);

    // Skid fills while the BFT stalls, then drains in order
    do_reset(2);
    leaf = 5'd7;
    port = 4'd9;
    repeat (6) cycle(1'b1, 32'h4000_0000 + 32'(m_addr), 1'b0, 1'b0, xf);
    check_eq("skid_full_ack", 64'(bus.ack_tx2user), 64'd0);
    held = bus.dout_tx2bft;
    cycle(1'b1, 32'h4000_0000 + 32'(m_addr), 1'b0, 1'b0, xf);
    check_eq("dout_stable", 64'(bus.dout_tx2bft), 64'(held));
    n_issued = 0;
    repeat (4) cycle(1'b0, 32'd0, 1'b1, 1'b0, xf);
    check_eq("drain_issued", 64'(n_issued), 64'd2);

    // Transfer and update in the same cycle at one remaining credit
    do_reset(2);
    leaf  = 5'd30;
    port  = 4'd5;
    guard = 0;
    while (m_credits != 1 && guard < 300) begin
      cycle(1'b1, 32'h5000_0000 + 32'(m_addr), 1'b1, 1'b0, xf);
      guard++;
    end
    check_eq("reach_credit1", 64'(bus.credits), 64'd1);
    cycle(1'b1, 32'h5000_0000 + 32'(m_addr), 1'b1, 1'b1, xf);
    check_eq("credits_net63", 64'(bus.credits), 64'd64);
    check_eq("ack_stays_run", 64'(bus.ack_tx2user), 64'd1);

    // Reset mid-operation with two buffered packets
    do_reset(2);
    repeat (4) cycle(1'b1, 32'h6000_0000 + 32'(m_addr), 1'b0, 1'b0, xf);
    check_eq("buffered_valid", 64'(bus.dout_tx2bft[VALID_BIT]), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("midrst_dout", 64'(bus.dout_tx2bft), 64'd0);
    check_eq("midrst_credits", 64'(bus.credits), 64'd128);
    do_reset(3);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, xf);
    cycle(1'b1, 32'h6666_0000, 1'b1, 1'b0, xf);
    check_eq("addr_after_rst", 64'(bus.dout_tx2bft[38:32]), 64'd0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, xf);

    // Randomized traffic; producer holds its word until accepted
    do_reset(2);
    for (int i = 0; i < 1500; i++) begin
      if (!hold) begin
        v = ($urandom_range(0, 3) != 0);
        d = $urandom;
        if ($urandom_range(0, 31) == 0) begin
          leaf = 5'($urandom);
          port = 4'($urandom);
        end
      end
      rdy = ($urandom_range(0, 3) != 0);
      u   = (m_credits <= 64) && ($urandom_range(0, (i < 750) ? 7 : 150) == 0);
      cycle(v, d, rdy, u, xf);
      hold = v && !xf;
    end
    repeat (4) cycle(1'b0, 32'd0, 1'b1, 1'b0, xf);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
